// File: rtl/bcd_count_ctrl.sv
// Gate-window measurement controller for a 3-digit BCD event counter.
// Clears the counter, counts synchronised event edges for GATE_CYCLES clocks, then latches the result.
module bcd_count_ctrl #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned GATE_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Evt_in,
  input  logic        Cnt_Cout,
  input  logic [11:0] Cnt_q,
  output logic        Cnt_Cin,
  output logic        Cnt_Rst_n,
  output logic [11:0] Result,
  output logic        Overflow,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StGate,
    StSettle,
    StLatch
  } state_e;

  localparam logic [GATE_W-1:0] GateLoad = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] CntOne   = GATE_W'(1);

  state_e                 state_q, state_d;
  logic [GATE_W-1:0]      gate_q, gate_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   evt_edge;
  logic                   sticky_q, sticky_d;
  logic [11:0]            result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   cin_q, cnt_rst_n_q, busy_q, done_q;

  assign evt_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

  // The gate counter is reused to time the two SETTLE cycles.
  always_comb begin
    state_d  = state_q;
    gate_d   = gate_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (Start) state_d = StClear;
      end
      StClear: begin
        sticky_d = 1'b0;
        gate_d   = GateLoad;
        state_d  = StGate;
      end
      StGate: begin
        if (gate_q == '0) begin
          gate_d  = CntOne;
          state_d = StSettle;
        end else begin
          gate_d = gate_q - CntOne;
        end
      end
      StSettle: begin
        if (gate_q == '0) state_d = StLatch;
        else              gate_d  = gate_q - CntOne;
      end
      StLatch: begin
        result_d = Cnt_q;
        ovf_d    = sticky_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (Cnt_Cout && (state_q == StGate || state_q == StSettle)) sticky_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      gate_q      <= '0;
      sync_q      <= '0;
      hist_q      <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= 12'h000;
      ovf_q       <= 1'b0;
      cin_q       <= 1'b0;
      cnt_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], Evt_in};
      hist_q      <= sync_q[SYNC_STAGES-1];
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      cin_q       <= evt_edge & (state_q == StGate);
      // Status outputs come straight from flops so they never glitch.
      cnt_rst_n_q <= (state_d != StClear);
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StLatch);
    end
  end

  assign Cnt_Cin   = cin_q;
  assign Cnt_Rst_n = cnt_rst_n_q;
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl: behavioural BCD counter, timeline model of each
// measurement window, per-cycle output comparison and directed scenarios with literal results.
module tb_bcd_count_ctrl;

  localparam int unsigned G = 2100;

  logic        clk = 1'b0;
  logic        rst_n, start, evt_in;
  logic        cnt_cout, cnt_cin, cnt_rst_n, overflow, busy, done;
  logic [11:0] cnt_q, result;

  int checks = 0, failures = 0;
  int cyc = 0;
  int cnt = 0;

  // Measurement model state
  bit          m_active = 1'b0;
  int          m_s = 0, m_n = 0;
  logic [11:0] m_result = 12'h000;
  logic        m_ovf = 1'b0;
  bit          evt_prev = 1'b0;
  bit          rise_buf[8];
  int          last_done = -1, prev_done = -1, done_cnt = 0;

  always #5 clk = ~clk;

  bcd_count_ctrl #(
    .GATE_CYCLES(G),
    .GATE_W     (16),
    .SYNC_STAGES(2)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Start    (start),
    .Evt_in   (evt_in),
    .Cnt_Cout (cnt_cout),
    .Cnt_q    (cnt_q),
    .Cnt_Cin  (cnt_cin),
    .Cnt_Rst_n(cnt_rst_n),
    .Result   (result),
    .Overflow (overflow),
    .Busy     (busy),
    .Done     (done)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Behavioural 000-999 counter driven by the controller
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) cnt <= 0;
    else if (cnt_cin) cnt <= (cnt == 999) ? 0 : cnt + 1;
  end
  assign cnt_q    = to_bcd(cnt);
  assign cnt_cout = cnt_cin && (cnt == 999);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline relative to the cycle s in which Start is accepted:
  // s+1 counter clear, edges rising in [s, s+G-1] are counted (Cin 3 cycles later),
  // Done at s+G+4, new Result from s+G+5.
  initial begin
    int   ph;
    bit   rise;
    logic e_busy, e_done, e_crst, e_cin;
    forever begin
      @(negedge clk);
      rise = evt_in & ~evt_prev;
      evt_prev = evt_in;
      rise_buf[cyc % 8] = rise;
      if (!rst_n) begin
        m_active = 1'b0;
        m_result = 12'h000;
        m_ovf    = 1'b0;
      end
      ph     = cyc - m_s;
      e_busy = m_active && ph >= 1 && ph <= int'(G) + 4;
      e_done = m_active && ph == int'(G) + 4;
      e_crst = !(m_active && ph == 1);
      e_cin  = m_active && ph >= 3 && ph <= int'(G) + 2 && rise_buf[(cyc + 5) % 8];
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("cnt_rst_n", cnt_rst_n, e_crst);
      chk("cnt_cin", cnt_cin, e_cin);
      chk("result", result, m_result);
      chk("overflow", overflow, m_ovf);
      if (done === 1'b1) begin
        prev_done = last_done;
        last_done = cyc;
        done_cnt++;
      end
      if (m_active && ph == int'(G) + 4) begin
        m_result = to_bcd(m_n % 1000);
        m_ovf    = (m_n >= 1000);
      end
      if (rst_n && start && (!m_active || ph >= int'(G) + 5)) begin
        m_active = 1'b1;
        m_s      = cyc;
        m_n      = 0;
        ph       = 0;
      end
      if (m_active && rise && ph >= 0 && ph <= int'(G) - 1) m_n++;
    end
  end

  function automatic logic evt_pat(input int mode, input int p);
    case (mode)
      0:       return (p % 10 == 5) && (p < 100);
      1:       return (p < int'(G)) && (p % 2 == 0);
      2:       return (p >= 20) && (p < 70);
      3:       return (p == int'(G) - 1) || (p == int'(G) + 1);
      4:       return (p % 10 == 5) && (p < 30);
      default: return 1'b0;
    endcase
  endfunction

  // mode 3 also raises Evt_in in the cycle before Start so its edge lands in CLEAR
  task automatic measure(input int mode, input logic [11:0] exp_res, input logic exp_ovf);
    int s, d0;
    d0 = done_cnt;
    s  = 0;
    evt_in = (mode == 3);
    start  = 1'b0;
    tick();
    for (int p = 0; p <= int'(G) + 4; p++) begin
      start  = (p == 0) || (mode == 4 && p == 500);
      evt_in = evt_pat(mode, p);
      if (p == 0) s = cyc;
      tick();
    end
    start  = 1'b0;
    evt_in = 1'b0;
    chk("done_latency", last_done - s, G + 4);
    chk("done_count", done_cnt - d0, 1);
    chk("result_lit", result, exp_res);
    chk("overflow_lit", overflow, exp_ovf);
    chk("busy_after", busy, 1'b0);
  endtask

  task automatic chk_reset_values();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cin", cnt_cin, 1'b0);
    chk("rst_cnt_rst_n", cnt_rst_n, 1'b1);
    chk("rst_result", result, 12'h000);
    chk("rst_overflow", overflow, 1'b0);
  endtask

  initial begin
    int d0;
    rst_n  = 1'b0;
    start  = 1'b0;
    evt_in = 1'b0;
    repeat (3) tick();
    chk_reset_values();
    rst_n = 1'b1;
    repeat (2) tick();

    measure(0, 12'h010, 1'b0);
    measure(1, 12'h050, 1'b1);

    // Reset in the middle of the gate window after five edges
    for (int p = 0; p < 80; p++) begin
      start  = (p == 0);
      evt_in = (p % 10 == 5) && (p < 50);
      tick();
    end
    chk("cnt_before_reset", cnt, 5);
    chk("busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    measure(0, 12'h010, 1'b0);

    measure(2, 12'h001, 1'b0);
    measure(3, 12'h001, 1'b0);
    measure(4, 12'h003, 1'b0);

    // Start held high: two back-to-back measurements
    d0    = done_cnt;
    start = 1'b1;
    repeat (2 * G + 10) tick();
    start = 1'b0;
    tick();
    chk("held_done_count", done_cnt - d0, 2);
    chk("held_done_gap", last_done - prev_done, G + 5);
    chk("held_busy_after", busy, 1'b0);
    chk("held_result", result, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
